// File: rtl/pwm_cfg_ctrl_if.sv
// Byte-stream, response-byte and PWM-core signal bundle of pwm_cfg_ctrl.
// The master side is the UART/PWM environment, the slave side is the controller.
interface pwm_cfg_ctrl_if #(
  parameter int PERIOD_W = 20
);
  logic                rx_valid;
  logic [7:0]          rx_data;
  logic                pwm_wrap;
  logic [PERIOD_W-1:0] pwm_period;
  logic [PERIOD_W-1:0] pwm_duty;
  logic                cfg_pending;
  logic                frame_ok;
  logic                frame_err;
  logic                tx_valid;
  logic [7:0]          tx_data;
  logic                tx_ready;

  modport master (
    output rx_valid, rx_data, pwm_wrap, tx_ready,
    input  pwm_period, pwm_duty, cfg_pending, frame_ok, frame_err, tx_valid, tx_data
  );

  modport slave (
    input  rx_valid, rx_data, pwm_wrap, tx_ready,
    output pwm_period, pwm_duty, cfg_pending, frame_ok, frame_err, tx_valid, tx_data
  );
endinterface

// File: rtl/pwm_cfg_ctrl.sv
// UART-framed PWM configuration: parses A5/CMD/B2/B1/B0/CHK frames into shadow
// registers, answers ACK/NAK, and commits shadows to the PWM core on period wrap.
module pwm_cfg_ctrl #(
  parameter int PERIOD_W   = 20,
  parameter int DEF_PERIOD = 1000,
  parameter int DEF_DUTY   = 500,
  parameter int TIMEOUT    = 27000
) (
  input logic           clk,
  input logic           rst,
  pwm_cfg_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_B2   = 3'd2,
    ST_B1   = 3'd3,
    ST_B0   = 3'd4,
    ST_CHK  = 3'd5,
    ST_RESP = 3'd6
  } state_t;

  localparam logic [7:0] SOF_BYTE   = 8'hA5;
  localparam logic [7:0] CMD_PERIOD = 8'h01;
  localparam logic [7:0] CMD_DUTY   = 8'h02;
  localparam logic [7:0] ACK_BYTE   = 8'h06;
  localparam logic [7:0] NAK_BYTE   = 8'h15;
  localparam int         TMR_W      = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0]    TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [PERIOD_W-1:0] DEF_PER_V = PERIOD_W'(DEF_PERIOD);
  localparam logic [PERIOD_W-1:0] DEF_DUT_V = PERIOD_W'(DEF_DUTY);

  function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] b2,
                                           input logic [7:0] b1, input logic [7:0] b0);
    return cmd ^ b2 ^ b1 ^ b0;
  endfunction

  function automatic logic [PERIOD_W-1:0] clamp_duty(input logic [PERIOD_W-1:0] duty,
                                                     input logic [PERIOD_W-1:0] period);
    return (duty > period) ? period : duty;
  endfunction

  state_t              state_r, state_nxt_s;
  logic [7:0]          cmd_r, b2_r, b1_r, b0_r;
  logic [TMR_W-1:0]    tmr_r;
  logic [PERIOD_W-1:0] shadow_period_r, shadow_duty_r;
  logic [PERIOD_W-1:0] pwm_period_r, pwm_duty_r;
  logic                cfg_pending_r, frame_ok_r, frame_err_r, tx_valid_r;
  logic [7:0]          tx_data_r;

  logic                in_frame_s, accept_s, timeout_s, chk_done_s, frame_good_s;
  logic                resp_done_s, wr_period_s, wr_duty_s, commit_s;
  logic [19:0]         value_s;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic: one state per accepted byte, timeout jumps to RESP
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: state_nxt_s = accept_s ? ST_CMD : ST_IDLE;
      ST_CMD:  state_nxt_s = accept_s ? ST_B2  : (timeout_s ? ST_RESP : ST_CMD);
      ST_B2:   state_nxt_s = accept_s ? ST_B1  : (timeout_s ? ST_RESP : ST_B2);
      ST_B1:   state_nxt_s = accept_s ? ST_B0  : (timeout_s ? ST_RESP : ST_B1);
      ST_B0:   state_nxt_s = accept_s ? ST_CHK : (timeout_s ? ST_RESP : ST_B0);
      ST_CHK:  state_nxt_s = (accept_s || timeout_s) ? ST_RESP : ST_CHK;
      ST_RESP: state_nxt_s = resp_done_s ? ST_IDLE : ST_RESP;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode: byte acceptance, frame verdict and commit strobes
  always_comb begin
    in_frame_s = 1'b0;
    accept_s   = 1'b0;
    case (state_r)
      ST_IDLE: accept_s = bus.rx_valid && (bus.rx_data == SOF_BYTE);
      ST_CMD, ST_B2, ST_B1, ST_B0, ST_CHK: begin
        in_frame_s = 1'b1;
        accept_s   = bus.rx_valid;
      end
      default: begin
        in_frame_s = 1'b0;
        accept_s   = 1'b0;
      end
    endcase
    value_s      = {b2_r[3:0], b1_r, b0_r};
    timeout_s    = in_frame_s && !bus.rx_valid && (tmr_r == TMR_LAST);
    chk_done_s   = accept_s && (state_r == ST_CHK);
    frame_good_s = chk_done_s
                   && (bus.rx_data == frame_chk(cmd_r, b2_r, b1_r, b0_r))
                   && ((cmd_r == CMD_PERIOD) || (cmd_r == CMD_DUTY))
                   && (b2_r[7:4] == 4'h0)
                   && !((cmd_r == CMD_PERIOD) && (value_s == 20'd0));
    wr_period_s  = frame_good_s && (cmd_r == CMD_PERIOD);
    wr_duty_s    = frame_good_s && (cmd_r == CMD_DUTY);
    resp_done_s  = (state_r == ST_RESP) && bus.tx_ready;
    commit_s     = bus.pwm_wrap && cfg_pending_r;
  end

  // Payload byte capture and inter-byte timer (cleared by every accepted byte)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_r <= 8'h00;
      b2_r  <= 8'h00;
      b1_r  <= 8'h00;
      b0_r  <= 8'h00;
      tmr_r <= '0;
    end else begin
      if (accept_s) begin
        case (state_r)
          ST_CMD:  cmd_r <= bus.rx_data;
          ST_B2:   b2_r  <= bus.rx_data;
          ST_B1:   b1_r  <= bus.rx_data;
          ST_B0:   b0_r  <= bus.rx_data;
          default: begin end
        endcase
      end
      tmr_r <= (in_frame_s && !bus.rx_valid && !timeout_s) ? tmr_r + TMR_W'(1) : '0;
    end
  end

  // Shadow/active registers; a commit reads the shadows before a same-cycle write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_period_r <= DEF_PER_V;
      shadow_duty_r   <= DEF_DUT_V;
      pwm_period_r    <= DEF_PER_V;
      pwm_duty_r      <= DEF_DUT_V;
      cfg_pending_r   <= 1'b0;
    end else begin
      if (wr_period_s) shadow_period_r <= PERIOD_W'(value_s);
      if (wr_duty_s)   shadow_duty_r   <= PERIOD_W'(value_s);
      if (commit_s) begin
        pwm_period_r <= shadow_period_r;
        pwm_duty_r   <= clamp_duty(shadow_duty_r, shadow_period_r);
      end
      if (wr_period_s || wr_duty_s) cfg_pending_r <= 1'b1;
      else if (commit_s)            cfg_pending_r <= 1'b0;
    end
  end

  // Status pulses and the ACK/NAK response byte held until tx_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_ok_r  <= 1'b0;
      frame_err_r <= 1'b0;
      tx_valid_r  <= 1'b0;
      tx_data_r   <= 8'h00;
    end else begin
      frame_ok_r  <= frame_good_s;
      frame_err_r <= (chk_done_s && !frame_good_s) || timeout_s;
      if (chk_done_s || timeout_s) begin
        tx_valid_r <= 1'b1;
        tx_data_r  <= frame_good_s ? ACK_BYTE : NAK_BYTE;
      end else if (resp_done_s) begin
        tx_valid_r <= 1'b0;
      end
    end
  end

  assign bus.pwm_period  = pwm_period_r;
  assign bus.pwm_duty    = pwm_duty_r;
  assign bus.cfg_pending = cfg_pending_r;
  assign bus.frame_ok    = frame_ok_r;
  assign bus.frame_err   = frame_err_r;
  assign bus.tx_valid    = tx_valid_r;
  assign bus.tx_data     = tx_data_r;

endmodule

// File: tb/tb_pwm_cfg_ctrl.sv
// Scoreboard bench for pwm_cfg_ctrl: the driver pushes expected status pulses,
// response bytes and PWM output states; a negedge monitor pops and compares.
module tb_pwm_cfg_ctrl;
  localparam int PW    = 20;
  localparam int DEF_P = 1000;
  localparam int DEF_D = 500;
  localparam int TO    = 40;

  logic clk = 1'b0;
  logic rst;
  pwm_cfg_ctrl_if #(.PERIOD_W(PW)) bus ();

  pwm_cfg_ctrl #(.PERIOD_W(PW), .DEF_PERIOD(DEF_P), .DEF_DUTY(DEF_D), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { bit ok; int cyc; } stat_t;
  typedef struct { logic [7:0] data; int first; int deadline; } txe_t;
  typedef struct { int eff; int per; int duty; bit pend; } out_t;

  stat_t stat_q[$];
  txe_t  tx_q[$];
  out_t  out_q[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int m_sh_p = DEF_P, m_sh_d = DEF_D, m_act_p = DEF_P, m_act_d = DEF_D;
  bit m_pend = 1'b0;
  int exp_p = DEF_P, exp_d = DEF_D;
  bit exp_pend = 1'b0;
  bit tx_seen = 1'b0;
  logic [7:0] fr [6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares everything the DUT presents against the queued expectations
  initial begin
    stat_t s;
    forever begin
      @(negedge clk);
      while (out_q.size() > 0 && out_q[0].eff <= cyc) begin
        exp_p = out_q[0].per; exp_d = out_q[0].duty; exp_pend = out_q[0].pend;
        void'(out_q.pop_front());
      end
      check("pwm_period", bus.pwm_period, exp_p);
      check("pwm_duty", bus.pwm_duty, exp_d);
      check("cfg_pending", bus.cfg_pending, exp_pend);
      if (bus.frame_ok || bus.frame_err) begin
        check("status_expected", int'(stat_q.size() != 0), 1);
        if (stat_q.size() != 0) begin
          s = stat_q.pop_front();
          check("frame_ok", bus.frame_ok, s.ok);
          check("frame_err", bus.frame_err, !s.ok);
          check("status_cycle", cyc, s.cyc);
        end
      end else if (stat_q.size() != 0 && cyc > stat_q[0].cyc) begin
        check("status_seen", bus.frame_ok | bus.frame_err, 1);
        void'(stat_q.pop_front());
      end
      if (bus.tx_valid) begin
        check("tx_expected", int'(tx_q.size() != 0), 1);
        if (tx_q.size() != 0) begin
          check("tx_data", bus.tx_data, tx_q[0].data);
          if (!tx_seen) check("tx_first_cycle", cyc, tx_q[0].first);
          tx_seen = 1'b1;
          if (bus.tx_ready) begin
            void'(tx_q.pop_front());
            tx_seen = 1'b0;
          end
        end
      end else if (tx_q.size() != 0 && cyc > tx_q[0].deadline) begin
        check("tx_seen", bus.tx_valid, 1);
        void'(tx_q.pop_front());
        tx_seen = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit w);
    bus.rx_valid = v; bus.rx_data = d; bus.pwm_wrap = w;
    tick();
    bus.rx_valid = 1'b0; bus.pwm_wrap = 1'b0;
  endtask

  // Reference: a wrap commits the old shadows, then any shadow write lands
  task automatic model_cycle(input bit wrap, input bit wr_p, input bit wr_d, input int val, input int eff);
    if (wrap && m_pend) begin
      m_act_p = m_sh_p;
      m_act_d = (m_sh_d < m_sh_p) ? m_sh_d : m_sh_p;
    end
    if (wr_p) m_sh_p = val;
    if (wr_d) m_sh_d = val;
    if (wr_p || wr_d) m_pend = 1'b1;
    else if (wrap)    m_pend = 1'b0;
    out_q.push_back('{eff, m_act_p, m_act_d, m_pend});
  endtask

  task automatic do_wrap();
    model_cycle(1'b1, 1'b0, 1'b0, 0, cyc + 1);
    drive(1'b0, 8'h00, 1'b1);
  endtask

  task automatic build(input logic [7:0] cmd, input logic [7:0] b2, input logic [7:0] b1, input logic [7:0] b0);
    fr[0] = 8'hA5; fr[1] = cmd; fr[2] = b2; fr[3] = b1; fr[4] = b0;
    fr[5] = cmd ^ b2 ^ b1 ^ b0;
  endtask

  // Sends fr[], optional wrap with the CHK byte, tx_ready held low for 'hold' cycles
  task automatic send_frame(input bit wrap_chk, input int hold, input int max_gap);
    int k, val;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, max_gap)) tick();
      if (i == 5) begin
        k   = cyc;
        val = {fr[2][3:0], fr[3], fr[4]};
        ok  = (fr[5] == (fr[1] ^ fr[2] ^ fr[3] ^ fr[4])) && (fr[1] == 8'h01 || fr[1] == 8'h02)
              && (fr[2][7:4] == 4'h0) && !(fr[1] == 8'h01 && val == 0);
        stat_q.push_back('{ok, k + 1});
        tx_q.push_back('{ok ? 8'h06 : 8'h15, k + 1, k + 2 + hold});
        model_cycle(wrap_chk, ok && fr[1] == 8'h01, ok && fr[1] == 8'h02, val, k + 1);
        if (hold > 0) bus.tx_ready = 1'b0;
      end
      drive(1'b1, fr[i], (i == 5) ? wrap_chk : 1'b0);
    end
    if (hold > 0) begin
      for (int j = 0; j < hold; j++) drive(1'b1, (j == hold - 1) ? 8'hA5 : 8'($urandom_range(0, 255)), 1'b0);
      bus.tx_ready = 1'b1;
      tick();
    end
  endtask

  task automatic send_timeout();
    int k;
    drive(1'b1, 8'hA5, 1'b0);
    drive(1'b1, 8'h01, 1'b0);
    k = cyc;
    stat_q.push_back('{1'b0, k + 1 + TO});
    tx_q.push_back('{8'h15, k + 1 + TO, k + 3 + TO});
    drive(1'b1, 8'h00, 1'b0);
    repeat (TO + 4) tick();
  endtask

  initial begin
    int kind, gap;
    logic [7:0] cmd, b2;
    logic [19:0] val;
    rst = 1'b1;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.pwm_wrap = 1'b0; bus.tx_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();

    // Non-SOF bytes in IDLE are ignored; a wrap with nothing pending changes nothing
    for (int i = 0; i < 8; i++) drive(1'b1, 8'($urandom_range(0, 164)), 1'b0);
    do_wrap();

    build(8'h01, 8'h00, 8'h07, 8'hD0); send_frame(1'b0, 0, 0); repeat (3) tick(); do_wrap();
    build(8'h02, 8'h00, 8'h0F, 8'hA0); send_frame(1'b0, 0, 0); repeat (3) tick(); do_wrap();
    build(8'h01, 8'h00, 8'h07, 8'hD0); fr[5] = 8'h00; send_frame(1'b0, 0, 0); repeat (3) tick(); do_wrap();
    send_timeout();
    build(8'h02, 8'h00, 8'h01, 8'h2C); send_frame(1'b0, 0, 1); repeat (3) tick(); do_wrap();
    build(8'h01, 8'h00, 8'h0B, 8'hB8); send_frame(1'b0, 10, 0); repeat (3) tick();
    build(8'h01, 8'h00, 8'h00, 8'h00); send_frame(1'b0, 0, 0); repeat (3) tick(); do_wrap();

    // CHK together with a wrap, then a second wrap five cycles later
    build(8'h02, 8'h00, 8'h02, 8'h58); send_frame(1'b1, 0, 0); repeat (4) tick(); do_wrap();
    repeat (3) tick();
    build(8'h01, 8'h00, 8'h0F, 8'hA0); send_frame(1'b0, 0, 0); repeat (2) tick();
    build(8'h02, 8'h00, 8'h03, 8'hE8); send_frame(1'b1, 0, 0); repeat (3) tick(); do_wrap();

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      cmd  = (kind == 0) ? 8'($urandom_range(0, 255)) : ((kind < 5) ? 8'h01 : 8'h02);
      val  = ($urandom_range(0, 1) == 1) ? 20'($urandom_range(0, 4095)) : 20'($urandom_range(0, 20'hFFFFF));
      if (kind == 1) val = 20'h0;
      b2 = {4'h0, val[19:16]};
      if (kind == 2) b2[7:4] = 4'($urandom_range(1, 15));
      build(cmd, b2, val[15:8], val[7:0]);
      if (kind == 3) fr[5] = fr[5] ^ 8'($urandom_range(1, 255));
      gap = ($urandom_range(0, 4) == 0) ? TO - 2 : 2;
      send_frame(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0, gap);
      repeat (2) tick();
      if ($urandom_range(0, 2) == 0) do_wrap();
    end

    // Reset arriving together with the B1 byte of a frame
    build(8'h01, 8'h00, 8'h09, 8'hC4); send_frame(1'b0, 0, 0); repeat (3) tick(); do_wrap();
    build(8'h02, 8'h00, 8'h01, 8'hF4); send_frame(1'b0, 0, 0); repeat (3) tick();
    drive(1'b1, 8'hA5, 1'b0); drive(1'b1, 8'h01, 1'b0); drive(1'b1, 8'h00, 1'b0);
    m_sh_p = DEF_P; m_sh_d = DEF_D; m_act_p = DEF_P; m_act_d = DEF_D; m_pend = 1'b0;
    out_q.push_back('{cyc, DEF_P, DEF_D, 1'b0});
    rst = 1'b1;
    drive(1'b1, 8'h07, 1'b0);
    rst = 1'b0;
    drive(1'b1, 8'hD0, 1'b0); drive(1'b1, 8'hD6, 1'b0);
    repeat (3) tick(); do_wrap();
    build(8'h01, 8'h00, 8'h07, 8'hD0); send_frame(1'b0, 0, 0); repeat (3) tick(); do_wrap();

    repeat (6) tick();
    check("status_queue_drained", stat_q.size(), 0);
    check("tx_queue_drained", tx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pwm_cfg_ctrl.md
PWM_CFG_CTRL -- requirements
Module: pwm_cfg_ctrl

Interface
REQ-001 Parameter PERIOD_W, default 20: width of the PWM period and duty values.
REQ-002 Parameter DEF_PERIOD, default 1000: active period loaded at reset.
REQ-003 Parameter DEF_DUTY, default 500: active duty loaded at reset.
REQ-004 Parameter TIMEOUT, default 27000: maximum clk cycles allowed between bytes inside one frame.
REQ-005 clk  in  1  sole clock; all logic is rising-edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 rx_valid  in  1  one-cycle strobe: a UART byte is available on rx_data.
REQ-008 rx_data  in  8  received byte.
REQ-009 pwm_wrap  in  1  one-cycle pulse from the PWM counter at its period end.
REQ-010 pwm_period  out  PERIOD_W  active period driven to the PWM core.
REQ-011 pwm_duty  out  PERIOD_W  active duty driven to the PWM core.
REQ-012 cfg_pending  out  1  high while shadow values await commit.
REQ-013 frame_ok / frame_err  out  1 each  one-cycle status pulses.
REQ-014 tx_valid  out  1, tx_data  out  8, tx_ready  in  1  response byte handshake toward the UART TX.

Function
REQ-015 Frame format SHALL be 6 bytes: 0xA5, CMD, B2, B1, B0, CHK; value = {B2[3:0],B1,B0}; CHK = CMD^B2^B1^B0.
REQ-016 FSM states SHALL be IDLE, CMD, B2, B1, B0, CHK, RESP; each accepted byte advances one state.
REQ-017 In IDLE, any byte other than 0xA5 SHALL be silently discarded, with no pulse and no response.
REQ-018 Frame SHALL be invalid if CHK mismatches, CMD is not 0x01/0x02, B2[7:4]!=0, or CMD=0x01 with value 0.
REQ-019 Valid CMD 0x01 SHALL write shadow_period; valid CMD 0x02 SHALL write shadow_duty; either write sets cfg_pending.
REQ-020 CHK byte accepted at cycle N: shadow write, cfg_pending, frame_ok|frame_err pulse and tx_valid all SHALL be visible at N+1; FSM enters RESP.
REQ-021 RESP SHALL hold tx_valid=1 with tx_data=0x06 (ACK) or 0x15 (NAK), stable until tx_ready; the cycle tx_valid&tx_ready is high -> tx_valid=0, FSM to IDLE.
REQ-022 rx_valid in RESP SHALL be dropped.
REQ-023 Timeout: in CMD..CHK, TIMEOUT cycles without rx_valid SHALL raise frame_err, send NAK, and leave shadows untouched; the counter reloads on every accepted byte.
REQ-024 Commit: on pwm_wrap with cfg_pending=1, pwm_period<=shadow_period, pwm_duty<=min(shadow_duty, shadow_period), cfg_pending<=0; outputs change only at commit.
REQ-025 pwm_wrap with cfg_pending=0 SHALL change nothing.
REQ-026 Shadow write and pwm_wrap in the same cycle: commit uses pre-write shadows; cfg_pending SHALL remain 1.
REQ-027 Comparisons and clamp SHALL be unsigned PERIOD_W-bit; no arithmetic wrap.

Reset
REQ-028 While rst is high: FSM=IDLE, shadow and active period/duty=DEF_PERIOD/DEF_DUTY, cfg_pending=0, frame_ok=frame_err=0, tx_valid=0, tx_data=0, timeout counter=0.
REQ-029 rst asserted mid-frame or in RESP SHALL abort immediately, with no response byte; no partial value SHALL reach the outputs.

Verification
REQ-030 Frame A5 01 00 07 D0 D6, tx_ready=1, then pwm_wrap -> frame_ok, tx_data=0x06; pwm_period=2000 after wrap, cfg_pending 1->0.
REQ-031 Frame A5 02 00 0F A0 AD, current period 2000, then pwm_wrap -> pwm_duty=2000 (clamped), ACK.
REQ-032 Frame A5 01 00 07 D0 00 (bad CHK) -> frame_err, NAK 0x15, outputs and cfg_pending unchanged.
REQ-033 A5 01 00, then TIMEOUT idle cycles -> frame_err and NAK at cycle TIMEOUT; the next valid frame is accepted normally.
REQ-034 tx_ready held 0 for 10 cycles in RESP, extra rx bytes injected -> tx_valid/tx_data stable, bytes dropped, IDLE after ready.
REQ-035 CHK byte accepted at N with pwm_wrap at N, then pwm_wrap at N+5 -> outputs stay at old values at N+1; new values at N+6.
REQ-036 rst asserted at the B1 byte -> outputs DEF_PERIOD/DEF_DUTY, tx_valid=0, FSM IDLE.
